// File: rtl/zcheck_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : zcheck_sequencer                                           |
// | Description : Sweeps an impedance check over every (channel, scale)      |
// |               pair, scale innermost. Each step raises zcheck_start to    |
// |               both front-end chips (RHD and RHS), waits until both have  |
// |               acknowledged (busy) and both have reported done with busy  |
// |               low again, then moves to the next pair. One done pulse     |
// |               marks the end of the sweep.                                |
// | Ports       : clk, rst (sync, active-high)                               |
// |               start, abort               - sweep control                 |
// |               zcheck_start, zcheck_global_channel, zcheck_scale          |
// |                                          - step request to the chips     |
// |               rhd_busy/rhd_done, rhs_busy/rhs_done - chip handshakes     |
// |               busy, done, error          - sweep status                  |
// | Options     : define ZCHECK_TIMEOUT_EN to bound every step to            |
// |               TIMEOUT_CYCLES cycles; on expiry the sweep ends with       |
// |               error=1 and a done pulse. Without it error is tied low.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module zcheck_sequencer #(
    parameter int NUM_CHANNELS   = 32,
    parameter int NUM_SCALES     = 3,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       zcheck_start,
    output logic [7:0] zcheck_global_channel,
    output logic [1:0] zcheck_scale,
    input  logic       rhd_busy,
    input  logic       rhd_done,
    input  logic       rhs_busy,
    input  logic       rhs_done,
    output logic       busy,
    output logic       done,
    output logic       error
);

    // Elaboration-time range checks on the configuration.
    generate
        if (NUM_CHANNELS < 1 || NUM_CHANNELS > 256) begin : g_bad_channels
            $error("zcheck_sequencer: NUM_CHANNELS must be 1..256");
        end
        if (NUM_SCALES < 1 || NUM_SCALES > 4) begin : g_bad_scales
            $error("zcheck_sequencer: NUM_SCALES must be 1..4");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("zcheck_sequencer: TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

    localparam logic [7:0] c_LAST_CH = 8'(NUM_CHANNELS - 1);
    localparam logic [1:0] c_LAST_SC = 2'(NUM_SCALES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_NEXT      = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    state_t     r_state;
    logic       r_zstart;
    logic [7:0] r_channel;
    logic [1:0] r_scale;
    logic       r_busy;
    logic       r_done;
    logic       r_rhd_flag;
    logic       r_rhs_flag;

`ifdef ZCHECK_TIMEOUT_EN
    localparam int c_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TMO_W-1:0] r_tmo;
    logic               r_error;
`endif

    // Sticky done flags including this cycle's done, so a done that arrives
    // in the same cycle both chips drop busy still lets the step complete.
    logic w_rhd_flag;
    logic w_rhs_flag;
    logic w_adv;

    assign w_rhd_flag = r_rhd_flag | rhd_done;
    assign w_rhs_flag = r_rhs_flag | rhs_done;
    assign w_adv      = (r_state == S_WAIT_DONE) && w_rhd_flag && w_rhs_flag &&
                        !rhd_busy && !rhs_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_zstart   <= 1'b0;
            r_channel  <= 8'd0;
            r_scale    <= 2'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rhd_flag <= 1'b0;
            r_rhs_flag <= 1'b0;
`ifdef ZCHECK_TIMEOUT_EN
            r_tmo      <= '0;
            r_error    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_channel  <= 8'd0;
                        r_scale    <= 2'd0;
                        r_zstart   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_rhd_flag <= 1'b0;
                        r_rhs_flag <= 1'b0;
                        r_state    <= S_ISSUE;
`ifdef ZCHECK_TIMEOUT_EN
                        r_tmo      <= '0;
                        r_error    <= 1'b0;
`endif
                    end
                end

                S_ISSUE, S_WAIT_DONE: begin
                    if (abort) begin
                        r_zstart   <= 1'b0;
                        r_busy     <= 1'b0;
                        r_rhd_flag <= 1'b0;
                        r_rhs_flag <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_rhd_flag <= w_rhd_flag;
                        r_rhs_flag <= w_rhs_flag;
                        if (r_state == S_ISSUE) begin
                            // Hold the request until both chips show busy together.
                            if (rhd_busy && rhs_busy) begin
                                r_zstart <= 1'b0;
                                r_state  <= S_WAIT_DONE;
                            end
                        end else if (w_adv) begin
                            r_rhd_flag <= 1'b0;
                            r_rhs_flag <= 1'b0;
                            r_state    <= S_NEXT;
                        end
`ifdef ZCHECK_TIMEOUT_EN
                        // Later assignments override the handshake outcome
                        // when the step budget runs out without completing.
                        if (!w_adv) begin
                            if (r_tmo == c_TMO_LAST) begin
                                r_error    <= 1'b1;
                                r_done     <= 1'b1;
                                r_zstart   <= 1'b0;
                                r_busy     <= 1'b0;
                                r_rhd_flag <= 1'b0;
                                r_rhs_flag <= 1'b0;
                                r_state    <= S_IDLE;
                            end else begin
                                r_tmo <= r_tmo + c_TMO_W'(1);
                            end
                        end
`endif
                    end
                end

                S_NEXT: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_channel == c_LAST_CH && r_scale == c_LAST_SC) begin
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        if (r_scale == c_LAST_SC) begin
                            r_scale   <= 2'd0;
                            r_channel <= r_channel + 8'd1;
                        end else begin
                            r_scale <= r_scale + 2'd1;
                        end
                        r_zstart <= 1'b1;
                        r_state  <= S_ISSUE;
`ifdef ZCHECK_TIMEOUT_EN
                        r_tmo    <= '0;
`endif
                    end
                end

                S_FINISH: begin
                    // done is high for this single cycle.
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_zstart <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign zcheck_start          = r_zstart;
    assign zcheck_global_channel = r_channel;
    assign zcheck_scale          = r_scale;
    assign busy                  = r_busy;
    assign done                  = r_done;
`ifdef ZCHECK_TIMEOUT_EN
    assign error                 = r_error;
`else
    assign error                 = 1'b0;
`endif

endmodule
`default_nettype wire
